// File: rtl/btn_debounce_oneshot.sv
// Push-button debouncer with a one-shot interrupt pulse per accepted press.
// Optional build macro: DB_RELEASE_PULSE_EN (also pulse DB_BTN on accepted release).
module btn_debounce_oneshot #(
   parameter int DB_COUNT     = 500000,
   parameter int PULSE_CYCLES = 1
) (
   input  logic CLK,
   input  logic RESETN,
   input  logic BTN,
   output logic DB_BTN,
   output logic DB_LEVEL
);

   localparam int CW = $clog2(DB_COUNT + 1);
   localparam int PW = $clog2(PULSE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DB_COUNT - 1);
   localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

`ifdef DB_RELEASE_PULSE_EN
   localparam bit REL_PULSE = 1'b1;
`else
   localparam bit REL_PULSE = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   logic          sync1_q, sync2_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          db_btn_q, db_level_q;
   logic          press_accept, release_accept, pulse_load;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      press_accept   = 1'b0;
      release_accept = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            // A mismatch on the acceptance cycle wins over the count.
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = PRESSED;
               cnt_d        = '0;
               press_accept = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESSED: begin
            if (!sync2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (sync2_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d        = IDLE;
               cnt_d          = '0;
               release_accept = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign pulse_load = press_accept | (REL_PULSE & release_accept);

   // A new acceptance restarts the pulse rather than extending it.
   always_comb begin
      if (pulse_load)
         pcnt_d = PULSE_LOAD;
      else if (pcnt_q != '0)
         pcnt_d = pcnt_q - PW'(1);
      else
         pcnt_d = pcnt_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         pcnt_q     <= '0;
         db_btn_q   <= 1'b0;
         db_level_q <= 1'b0;
      end else begin
         sync1_q    <= BTN;
         sync2_q    <= sync1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pcnt_q     <= pcnt_d;
         db_btn_q   <= (pcnt_d != '0);
         db_level_q <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      end
   end

   assign DB_BTN   = db_btn_q;
   assign DB_LEVEL = db_level_q;

endmodule

// File: tb/tb_btn_debounce_oneshot.sv
// Scoreboard bench for btn_debounce_oneshot: random and directed button waveforms
// against a run-length reference model; honours DB_RELEASE_PULSE_EN like the design.
module tb_btn_debounce_oneshot;

   localparam int DB_COUNT     = 4;
   localparam int PULSE_CYCLES = 2;

`ifdef DB_RELEASE_PULSE_EN
   localparam bit REL_PULSE = 1'b1;
`else
   localparam bit REL_PULSE = 1'b0;
`endif

   typedef struct packed {
      logic level;
      logic btn;
   } exp_t;

   logic CLK = 1'b0;
   logic RESETN = 1'b0;
   logic BTN = 1'b1;
   logic DB_BTN, DB_LEVEL;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   rises    = 0;
   logic btn_prev = 1'b0;

   exp_t exp_q[$];
   exp_t last_exp;

   // Reference model state: debounced level, run length of disagreeing samples,
   // cycles of pulse left, and the raw samples still travelling through the synchronizer.
   bit   m_level;
   int   m_run;
   int   m_pulse;
   bit   m_hist[$];

   btn_debounce_oneshot #(
      .DB_COUNT    (DB_COUNT),
      .PULSE_CYCLES(PULSE_CYCLES)
   ) dut (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .BTN     (BTN),
      .DB_BTN  (DB_BTN),
      .DB_LEVEL(DB_LEVEL)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   function automatic void model_reset();
      m_level = 1'b0;
      m_run   = 0;
      m_pulse = 0;
      m_hist.delete();
      m_hist.push_back(1'b0);
      m_hist.push_back(1'b0);
   endfunction

   // One clock edge of the model: the level flips once DB_COUNT+1 consecutive
   // synchronized samples disagree with it.
   function automatic void model_step(input bit b);
      bit   s;
      bit   acc_press, acc_rel;
      exp_t e;
      acc_press = 1'b0;
      acc_rel   = 1'b0;
      m_hist.push_back(b);
      s = m_hist.pop_front();
      if (s != m_level) begin
         m_run++;
         if (m_run == DB_COUNT + 1) begin
            m_level   = s;
            m_run     = 0;
            acc_press = s;
            acc_rel   = !s;
         end
      end else begin
         m_run = 0;
      end
      if (acc_press || (REL_PULSE && acc_rel))
         m_pulse = PULSE_CYCLES;
      else if (m_pulse > 0)
         m_pulse--;
      e.level = m_level;
      e.btn   = (m_pulse > 0);
      last_exp = e;
      exp_q.push_back(e);
   endfunction

   task automatic drive(input bit b);
      @(negedge CLK);
      BTN = b;
      model_step(b);
   endtask

   task automatic hold(input bit b, input int n);
      for (int i = 0; i < n; i++) drive(b);
   endtask

   task automatic do_reset(input int n, input bit b);
      @(negedge CLK);
      RESETN = 1'b0;
      BTN    = b;
      exp_q.delete();
      model_reset();
      repeat (n) @(negedge CLK);
      RESETN = 1'b1;
      model_step(b);
   endtask

   // Monitor: every edge out of reset consumes one expectation.
   always @(posedge CLK) begin
      exp_t e;
      #1;
      if (!RESETN) begin
         check("reset_db_level", DB_LEVEL, 0);
         check("reset_db_btn", DB_BTN, 0);
      end else if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty at %0t: got no expectation, expected one per edge", $time);
      end else begin
         e = exp_q.pop_front();
         check("db_level", DB_LEVEL, e.level);
         check("db_btn", DB_BTN, e.btn);
      end
      if (DB_BTN && !btn_prev) rises++;
      btn_prev = DB_BTN;
   end

   initial begin
      #500us;
      $display("FAIL watchdog at %0t: got no completion, expected bench to finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  r0;
      bit  found;
      model_reset();

      // Reset held with the button pressed, then the first press.
      do_reset(10, 1'b1);
      hold(1'b1, 14);
      hold(1'b0, 12);

      // Bounce shorter than the debounce window.
      hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3);
      hold(1'b0, 12);

      // Long hold gives one pulse only.
      r0 = rises;
      hold(1'b1, 50);
      check("single_pulse_on_hold", rises - r0, 1);
      r0 = rises;
      hold(1'b0, 12);
      check("release_pulses", rises - r0, REL_PULSE ? 1 : 0);

      // Release glitch while pressed.
      hold(1'b1, 12);
      r0 = rises;
      hold(1'b0, 2);
      hold(1'b1, 12);
      check("glitch_no_pulse", rises - r0, 0);
      hold(1'b0, 12);

      // Reset during the first pulse cycle.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         drive(1'b1);
         found = last_exp.btn;
      end
      check("pulse_reached", found, 1);
      @(posedge CLK);
      #3;
      RESETN = 1'b0;
      #1;
      check("async_reset_db_btn", DB_BTN, 0);
      check("async_reset_db_level", DB_LEVEL, 0);
      do_reset(3, 1'b1);
      hold(1'b1, 12);
      hold(1'b0, 12);

      // Random button waveforms.
      for (int k = 0; k < 150; k++)
         hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
      hold(1'b0, 12);

      @(posedge CLK);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_debounce_oneshot.md
# btn_debounce_oneshot

Debounces a raw, asynchronous push-button input and converts each qualified press into a fixed-length, single-clock-domain interrupt pulse. It sits directly upstream of the OTTER CPU's `INTR` input in the board wrapper and drives the `DB_BTN` net. It runs in the 50 MHz CPU clock domain, so the pulse is seen by the CPU exactly once per press.

## Interface
- `DB_COUNT`, default 500000: number of consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥1.
- `PULSE_CYCLES`, default 1: width of `DB_BTN` pulse in clock cycles; must be ≥1.
- `CLK`  in  1  CPU clock (clk_50 domain).
- `RESETN`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `BTN`  in  1  raw button, asynchronous to `CLK`, active-high.
- `DB_BTN`  out  1  one-shot pulse, high `PULSE_CYCLES` cycles per accepted press; drives CPU `INTR`.
- `DB_LEVEL`  out  1  debounced button level.

## Operation
- Two-flop synchronizer `sync1 -> sync2` on `BTN`, both reset to 0. Only `sync2` feeds the FSM.
- Stable counter `cnt`, width `$clog2(DB_COUNT+1)`, resets to 0. It never wraps because it is cleared on every state change.
- FSM states, reset state `IDLE`:
  - `IDLE` (`DB_LEVEL`=0): `sync2`=1 → `PRESS_WAIT`, `cnt`←0.
  - `PRESS_WAIT`: if `sync2`=0 → `IDLE`, `cnt`←0. Else if `cnt`==`DB_COUNT`-1 → `PRESSED` and load the pulse counter. Else `cnt`++.
  - `PRESSED` (`DB_LEVEL`=1): `sync2`=0 → `RELEASE_WAIT`, `cnt`←0.
  - `RELEASE_WAIT` (`DB_LEVEL`=1): if `sync2`=1 → `PRESSED`, `cnt`←0. Else if `cnt`==`DB_COUNT`-1 → `IDLE`. Else `cnt`++.
- Pulse counter `pcnt`, width `$clog2(PULSE_CYCLES+1)`, resets to 0.
  - It is loaded with `PULSE_CYCLES` on a press acceptance and decremented while nonzero.
  - `DB_BTN` = registered (`pcnt`≠0).
  - A new acceptance while `pcnt`≠0 reloads `pcnt` to `PULSE_CYCLES`. The pulses merge into one; there is no extension beyond `PULSE_CYCLES` from the last acceptance.
- `DB_LEVEL` and `DB_BTN` are registered outputs. There are no combinational paths from `BTN`.
- Any glitch shorter than `DB_COUNT` cycles (measured at `sync2`) produces no output change.

## Timing
- Reset values: `DB_LEVEL`=0, `DB_BTN`=0, state `IDLE`, `cnt`=0, `pcnt`=0, `sync1`=`sync2`=0.
- `RESETN` low clears everything immediately and asynchronously, including an in-flight pulse. Release is assumed synchronized externally, e.g. by the wrapper's reset synchronizer.
- Press latency: if `BTN` is first sampled high at edge 0 and held, `DB_LEVEL` and `DB_BTN` rise at edge `DB_COUNT`+2.
- `DB_BTN` is high for exactly `PULSE_CYCLES` consecutive cycles, then low.
- Release latency: `DB_LEVEL` falls at edge `DB_COUNT`+2 after `BTN` is first sampled low (held).
- Simultaneous events: if the acceptance edge and an `sync2` mismatch coincide, the state check governs. In `PRESS_WAIT`, mismatch wins (`sync2`=0 → `IDLE`, no pulse).
- `BTN` held high indefinitely produces one pulse only.

## Configuration
- `DB_RELEASE_PULSE_EN`
  - Defined: the `RELEASE_WAIT`→`IDLE` acceptance also loads `pcnt`, so `DB_BTN` pulses `PULSE_CYCLES` cycles on release, coincident with `DB_LEVEL` falling.
  - Undefined: only press acceptance pulses, and release changes `DB_LEVEL` only.

## Test plan
Bench parameters: `DB_COUNT`=4, `PULSE_CYCLES`=2.
- Reset: hold `RESETN`=0 with `BTN`=1 for 10 cycles → `DB_LEVEL`=0, `DB_BTN`=0 throughout. Release reset, hold `BTN`=1 → `DB_LEVEL` rises at edge 6 after the first sample, `DB_BTN` high edges 6–7, then low.
- Bounce: toggle `BTN` 1,0,1,0 with each level held 3 cycles, then hold 0 → `DB_LEVEL` and `DB_BTN` stay 0.
- Hold/release: hold `BTN`=1 for 50 cycles → exactly one 2-cycle `DB_BTN` pulse. Drop `BTN` to 0 → `DB_LEVEL` falls 6 edges later, with no `DB_BTN` pulse (macro undefined).
- Release glitch: in `PRESSED`, drop `BTN` low for 2 cycles, then return high → `DB_LEVEL` stays 1 and no new pulse.
- Reset mid-pulse: assert `RESETN`=0 during the first `DB_BTN` cycle → `DB_BTN` and `DB_LEVEL` go 0 before the next edge; the state returns to `IDLE`.
- `DB_RELEASE_PULSE_EN` defined: press, then release → two 2-cycle `DB_BTN` pulses, the second aligned with `DB_LEVEL` falling.
